kbd_scancode_decoder: RTL and testbench

Consumes the byte stream from the PS/2 bit receiver (`dout`, `dout_new`, `parity_ok`) and decodes Set-2 scan-code sequences into key events. Handles the 0xE0 extended prefix, the 0xF0 break prefix and their combination. Emits one registered event per completed sequence: 9-bit key code plus make/break. Sits between the bit receiver and the game key-state/control logic.

---
 rtl/kbd_scancode_decoder.sv | 175 +++++++++++++++++
 tb/tb_kbd_scancode_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: E0/F0 prefix FSM turning received bytes into key make/break events.
// Latency: one cycle; every output is registered and pulses appear the cycle after the causing din_new.
// No backpressure: a byte is consumed whenever din_new is high. Optional KBD_REPEAT_FILTER_EN drops typematic repeats.
module kbd_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [7:0]           din,
  input  logic                 din_new,
  input  logic                 parity_ok,
  output logic [8:0]           key_code,
  output logic                 make,
  output logic                 key_valid,
  output logic                 parity_err,
  output logic                 proto_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Compare against TIMEOUT_CYCLES-2 so the counter register is about to reach TIMEOUT_CYCLES-1 on the abort edge.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE_ST    = 2'd0,
    EXT_ST     = 2'd1,
    BRK_ST     = 2'd2,
    EXT_BRK_ST = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_hit;
  logic             ignored;
  logic             emit;
  logic             emit_make;
  logic [8:0]       emit_code;
  logic             emit_ok;
  logic             perr_nxt;
  logic             proto_nxt;

  assign timeout_hit = (state != IDLE_ST) && (to_cnt == TO_LAST);

  // Bytes that carry no key information (ACK, BAT, echo, resend, pause prefix, errors)
  always_comb begin
    ignored = 1'b0;
    case (din)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ignored = 1'b1;
      default:                                          ignored = 1'b0;
    endcase
  end

  // Next-state and event decode; bad parity beats everything, an arriving byte beats a timeout
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_make = 1'b0;
    emit_code = {1'b0, din};
    perr_nxt  = 1'b0;
    proto_nxt = 1'b0;
    if (din_new) begin
      if (!parity_ok) begin
        perr_nxt  = 1'b1;
        state_nxt = IDLE_ST;
      end else if (!ignored) begin
        case (state)
          IDLE_ST: begin
            if (din == 8'hE0)      state_nxt = EXT_ST;
            else if (din == 8'hF0) state_nxt = BRK_ST;
            else begin
              emit      = 1'b1;
              emit_make = 1'b1;
            end
          end
          EXT_ST: begin
            if (din == 8'hF0)      state_nxt = EXT_BRK_ST;
            else if (din != 8'hE0) begin
              emit      = 1'b1;
              emit_make = 1'b1;
              emit_code = {1'b1, din};
              state_nxt = IDLE_ST;
            end
          end
          BRK_ST: begin
            if (din == 8'hE0) begin
              proto_nxt = 1'b1;
              state_nxt = EXT_ST;
            end else if (din != 8'hF0) begin
              emit      = 1'b1;
              state_nxt = IDLE_ST;
            end
          end
          EXT_BRK_ST: begin
            if (din == 8'hE0) begin
              proto_nxt = 1'b1;
              state_nxt = EXT_ST;
            end else if (din != 8'hF0) begin
              emit      = 1'b1;
              emit_code = {1'b1, din};
              state_nxt = IDLE_ST;
            end
          end
          default: state_nxt = IDLE_ST;
        endcase
      end
    end else if (timeout_hit) begin
      proto_nxt = 1'b1;
      state_nxt = IDLE_ST;
    end
  end

`ifdef KBD_REPEAT_FILTER_EN
  logic [8:0] held_code;
  logic       held_valid;

  // A make matching the currently held key is an auto-repeat and is swallowed
  always_comb begin
    emit_ok = emit;
    if (emit && emit_make && held_valid && (held_code == emit_code)) emit_ok = 1'b0;
  end

  // Track the most recently pressed key until its release
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      held_code  <= '0;
      held_valid <= 1'b0;
    end else if (emit_ok && emit_make) begin
      held_code  <= emit_code;
      held_valid <= 1'b1;
    end else if (emit && !emit_make && (held_code == emit_code)) begin
      held_valid <= 1'b0;
    end
  end
`else
  // Every decoded make is forwarded
  always_comb emit_ok = emit;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE_ST;
    else         state <= state_nxt;
  end

  // Inter-byte timeout counter, idle-cleared and restarted by each byte
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                          to_cnt <= '0;
    else if (din_new || state == IDLE_ST) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + CNT_W'(1);
  end

  // Registered event and error outputs; err_cnt moves together with its pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_code   <= '0;
      make       <= 1'b0;
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      proto_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      key_valid  <= emit_ok;
      parity_err <= perr_nxt;
      proto_err  <= proto_nxt;
      if (emit_ok) begin
        key_code <= emit_code;
        make     <= emit_make;
      end
      if ((perr_nxt || proto_nxt) && (err_cnt != {ERR_CNT_W{1'b1}}))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Self-checking bench for kbd_scancode_decoder: directed sequences plus random byte streams.
// Reference model tracks only two prefix flags (extended, break) and the last event.
// Timeout shortened to keep the run small.
module tb_kbd_scancode_decoder;

  localparam int T  = 20;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          din_new = 1'b0;
  logic          parity_ok = 1'b1;
  logic [8:0]    key_code;
  logic          make;
  logic          key_valid;
  logic          parity_err;
  logic          proto_err;
  logic [EW-1:0] err_cnt;

  kbd_scancode_decoder #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(EW)) dut (
    .clk(clk), .resetN(resetN), .din(din), .din_new(din_new), .parity_ok(parity_ok),
    .key_code(key_code), .make(make), .key_valid(key_valid),
    .parity_err(parity_err), .proto_err(proto_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // reference model state
  bit       m_ext, m_brk;
  bit [8:0] m_code;
  bit       m_make;
  int       m_err;
  bit       e_kv, e_perr, e_proto;
  bit [8:0] m_held;
  bit       m_held_v;
  int       n_makes, n_breaks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_code = 0; m_make = 0; m_err = 0;
    e_kv = 0; e_perr = 0; e_proto = 0; m_held = 0; m_held_v = 0;
  endtask

  function automatic bit is_ign(input bit [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hEE ||
           b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic bump_err();
    if (m_err < (1 << EW) - 1) m_err++;
  endtask

  // Prefix rules: F0 marks break, E0 marks extended (and is illegal after F0), anything else completes.
  task automatic model_step(input bit [7:0] b, input bit p);
    bit [8:0] c;
    e_kv = 0; e_perr = 0; e_proto = 0;
    if (!p) begin
      e_perr = 1; m_ext = 0; m_brk = 0; bump_err();
    end else if (is_ign(b)) begin
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      if (m_brk) begin e_proto = 1; bump_err(); end
      m_ext = 1; m_brk = 0;
    end else begin
      c = {m_ext, b};
      e_kv = 1;
`ifdef KBD_REPEAT_FILTER_EN
      if (!m_brk && m_held_v && m_held == c) e_kv = 0;
      if (!m_brk && e_kv) begin m_held = c; m_held_v = 1; end
      if (m_brk && m_held == c) m_held_v = 0;
`endif
      if (e_kv) begin m_code = c; m_make = !m_brk; end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(e_kv));
    chk({tag, ".key_code"}, 32'(key_code), 32'(m_code));
    chk({tag, ".make"}, 32'(make), 32'(m_make));
    chk({tag, ".parity_err"}, 32'(parity_err), 32'(e_perr));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(e_proto));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    if (key_valid === 1'b1 && make === 1'b1) n_makes++;
    if (key_valid === 1'b1 && make === 1'b0) n_breaks++;
  endtask

  task automatic send_byte(input bit [7:0] b, input bit p);
    din = b; parity_ok = p; din_new = 1'b1;
    @(posedge clk); #1;
    din_new = 1'b0; parity_ok = 1'b1; din = $urandom_range(0, 255);
    model_step(b, p);
    check_outs($sformatf("byte_%02h", b));
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    e_kv = 0; e_perr = 0; e_proto = 0;
    check_outs(tag);
  endtask

  initial begin
    bit [7:0] b;
    bit       p;
    int       r;
    model_reset();
    n_makes = 0; n_breaks = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1; check_outs("reset");
    resetN = 1'b1;
    @(negedge clk);

    // A press / release
    send_byte(8'h1C, 1);
    chk("a_press_code", 32'(key_code), 32'h01C);
    send_byte(8'hF0, 1);
    send_byte(8'h1C, 1);
    chk("a_release_make", 32'(make), 32'h0);

    // up arrow press / release
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    chk("up_press_code", 32'(key_code), 32'h175);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    chk("up_release_make", 32'(make), 32'h0);

    // bad parity drops pending prefix
    send_byte(8'hE0, 0);
    chk("perr_cnt", 32'(err_cnt), 32'h1);
    send_byte(8'h29, 1);
    chk("after_perr_code", 32'(key_code), 32'h029);

    // ignored bytes, illegal E0 after F0
    send_byte(8'hFA, 1); send_byte(8'hAA, 1);
    send_byte(8'hF0, 1); send_byte(8'hE0, 1); send_byte(8'h6B, 1);
    chk("illegal_then_code", 32'(key_code), 32'h16B);

    // timeout: proto_err exactly T-1 cycles after the F0
    send_byte(8'hF0, 1);
    for (int k = 1; k <= T - 2; k++) idle_cycle("to_wait");
    @(posedge clk); #1;
    e_kv = 0; e_perr = 0; e_proto = 1; bump_err(); m_ext = 0; m_brk = 0;
    check_outs("timeout");
    idle_cycle("after_timeout");
    send_byte(8'h29, 1);

    // byte arriving on the exact timeout cycle wins
    send_byte(8'hF0, 1);
    for (int k = 1; k <= T - 2; k++) idle_cycle("to_race_wait");
    send_byte(8'h1C, 1);
    for (int k = 0; k < T + 2; k++) idle_cycle("to_race_after");

    // typematic repeat
    n_makes = 0; n_breaks = 0;
    send_byte(8'h1C, 1); send_byte(8'h1C, 1); send_byte(8'h1C, 1);
    send_byte(8'hF0, 1); send_byte(8'h1C, 1); send_byte(8'h1C, 1);
`ifdef KBD_REPEAT_FILTER_EN
    chk("repeat_makes", 32'(n_makes), 32'd2);
`else
    chk("repeat_makes", 32'(n_makes), 32'd4);
`endif
    chk("repeat_breaks", 32'(n_breaks), 32'd1);

    // randomized byte streams with short gaps
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      p = 1;
      if (r < 22)      b = 8'hE0;
      else if (r < 42) b = 8'hF0;
      else if (r < 50) begin
        case ($urandom_range(0, 6))
          0: b = 8'h00; 1: b = 8'hAA; 2: b = 8'hE1; 3: b = 8'hEE;
          4: b = 8'hFA; 5: b = 8'hFE; default: b = 8'hFF;
        endcase
      end else begin
        b = $urandom_range(1, 255);
        if (r < 55) p = 0;
      end
      send_byte(b, p);
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) idle_cycle("rand_gap");
    end

    // reset in the middle of a sequence
    send_byte(8'h5A, 1);
    send_byte(8'hE0, 1);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_outs("mid_reset");
    @(negedge clk); resetN = 1'b1;
    send_byte(8'h29, 1);
    chk("post_reset_code", 32'(key_code), 32'h029);

    // error counter saturation
    for (int i = 0; i < 260; i++) send_byte(8'h33, 0);
    chk("err_sat", 32'(err_cnt), 32'hFF);
    send_byte(8'hF0, 1); send_byte(8'hE0, 1);
    chk("err_sat_hold", 32'(err_cnt), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
